// File: rtl/fas_pkg.sv
// Shared widths, defaults and FSM encoding for the FFT frame controller.
// Bins arrive packed as {re, im}, both signed two's complement.
package fas_pkg;

    localparam int N_DEF         = 16;
    localparam int FRAME_NUM_DEF = 10;

    localparam int SAMP_W = 16;
    localparam int RE_W   = 16;
    localparam int IM_W   = 16;
    localparam int BIN_W  = RE_W + IM_W;
    localparam int MAG_W  = 2 * RE_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fas_peak_detect.sv
// Per-beat |bin|^2 with running maximum; peak_idx_o already includes the current beat.
// Bin 0 always seeds the maximum; later bins win only when strictly larger.
module fas_peak_detect
    import fas_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   beat_i,
    input  logic [$clog2(N)-1:0]   idx_i,
    input  logic [BIN_W-1:0]       bin_i,
    output logic [$clog2(N)-1:0]   peak_idx_o
);

    localparam int AW = $clog2(N);

    logic signed [RE_W-1:0]   re;
    logic signed [IM_W-1:0]   im;
    logic signed [2*RE_W-1:0] re_sq;
    logic signed [2*IM_W-1:0] im_sq;
    logic [MAG_W-1:0]         mag;
    logic                     take;

    logic [MAG_W-1:0] max_q;
    logic [AW-1:0]    idx_q;

    assign re    = bin_i[BIN_W-1 -: RE_W];
    assign im    = bin_i[IM_W-1:0];
    assign re_sq = re * re;
    assign im_sq = im * im;
    // Squares are never negative, so zero-extension gives the exact unsigned sum.
    assign mag   = {1'b0, re_sq} + {1'b0, im_sq};

    assign take       = (idx_i == '0) || (mag > max_q);
    assign peak_idx_o = take ? idx_i : idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (beat_i && take) begin
            max_q <= mag;
            idx_q <= idx_i;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Ping-pong sample banks feeding an FFT core, dispatching full banks in strict alternation.
// Samples into a full bank are dropped (sticky overflow); peak bin reported one cycle after the last beat.
module fft_frame_ctrl
    import fas_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int FRAME_NUM = FRAME_NUM_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fir_valid,
    input  logic [SAMP_W-1:0]     fir_d,
    output logic                  fft_start,
    input  logic [$clog2(N)-1:0]  fft_rd_addr,
    output logic [SAMP_W-1:0]     fft_rd_data,
    input  logic                  fft_bin_valid,
    input  logic [BIN_W-1:0]      fft_bin,
    output logic                  freq_valid,
    output logic [$clog2(N)-1:0]  freq,
    output logic                  done,
    output logic                  overflow
);

    localparam int AW = $clog2(N);
    localparam int FW = $clog2(FRAME_NUM + 1);

    logic [SAMP_W-1:0] bank0_q [N];
    logic [SAMP_W-1:0] bank1_q [N];

    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          wr_en;

    state_e        state_q;
    logic          disp_bank_q;
    logic [AW-1:0] bin_cnt_q;
    logic [FW-1:0] frame_cnt_q;
    logic          fft_start_q;
    logic          freq_valid_q;
    logic [AW-1:0] freq_q;
    logic          done_q;

    logic          beat;
    logic          last_beat;
    logic [AW-1:0] peak_idx;

    assign beat      = (state_q == ST_RUN) && fft_bin_valid;
    assign last_beat = beat && (bin_cnt_q == AW'(N - 1));

    // Release and fill use the registered full flags, so a write aimed at the
    // bank being released this cycle still sees it full and is dropped.
    always_comb begin
        wr_en      = 1'b0;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        overflow_d = overflow_q;
        full_d     = full_q;
        if (last_beat) begin
            full_d[disp_bank_q] = 1'b0;
        end
        if (fir_valid && !done_q) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == AW'(N - 1)) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            full_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank_q) begin
                bank1_q[wr_cnt_q] <= fir_d;
            end else begin
                bank0_q[wr_cnt_q] <= fir_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            disp_bank_q  <= 1'b0;
            bin_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            fft_start_q  <= 1'b0;
            freq_valid_q <= 1'b0;
            freq_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            fft_start_q  <= 1'b0;
            freq_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (full_q[disp_bank_q] && !done_q) begin
                        fft_start_q <= 1'b1;
                        bin_cnt_q   <= '0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        bin_cnt_q <= bin_cnt_q + 1'b1;
                        if (last_beat) begin
                            freq_q       <= peak_idx;
                            freq_valid_q <= 1'b1;
                            disp_bank_q  <= ~disp_bank_q;
                            frame_cnt_q  <= frame_cnt_q + 1'b1;
                            state_q      <= ST_IDLE;
                            if (frame_cnt_q == FW'(FRAME_NUM - 1)) begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fas_peak_detect #(
        .N (N)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .beat_i     (beat),
        .idx_i      (bin_cnt_q),
        .bin_i      (fft_bin),
        .peak_idx_o (peak_idx)
    );

    assign fft_rd_data = disp_bank_q ? bank1_q[fft_rd_addr] : bank0_q[fft_rd_addr];
    assign fft_start   = fft_start_q;
    assign freq_valid  = freq_valid_q;
    assign freq        = freq_q;
    assign done        = done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: bank fill/dispatch, peak search, overflow, done and mid-frame reset.
module tb_fft_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        fir_valid;
    logic [15:0] fir_d;
    logic        fft_start;
    logic [3:0]  fft_rd_addr;
    logic [15:0] fft_rd_data;
    logic        fft_bin_valid;
    logic [31:0] fft_bin;
    logic        freq_valid;
    logic [3:0]  freq;
    logic        done;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    int fv_cnt = 0;

    fft_frame_ctrl #(
        .N         (16),
        .FRAME_NUM (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fir_valid     (fir_valid),
        .fir_d         (fir_d),
        .fft_start     (fft_start),
        .fft_rd_addr   (fft_rd_addr),
        .fft_rd_data   (fft_rd_data),
        .fft_bin_valid (fft_bin_valid),
        .fft_bin       (fft_bin),
        .freq_valid    (freq_valid),
        .freq          (freq),
        .done          (done),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fft_start === 1'b1) start_cnt <= start_cnt + 1;
        if (freq_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        fir_valid = 1'b0;
        fft_bin_valid = 1'b0;
        fft_bin = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_samples(input int cnt, input int base, input int step);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            fir_valid = 1'b1;
            fir_d = 16'(base + i * step);
        end
        @(negedge clk);
        fir_valid = 1'b0;
    endtask

    task automatic send_bins(input int a, input logic [31:0] va, input int b, input logic [31:0] vb,
                             input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            fft_bin_valid = 1'b1;
            fft_bin = (i == a) ? va : ((i == b) ? vb : 32'h0);
        end
        @(negedge clk);
        fft_bin_valid = 1'b0;
        fft_bin = '0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = -1;
        for (int c = 0; c < 8; c++) begin
            if (cyc < 0 && fft_start === 1'b1) cyc = c;
            if (cyc < 0) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (fft_start !== 1'b0) begin n_err++; $display("FAIL reset_fft_start: got %b want 0", fft_start); end
        n_cmp++; if (freq_valid !== 1'b0) begin n_err++; $display("FAIL reset_freq_valid: got %b want 0", freq_valid); end
        n_cmp++; if (freq !== 4'd0) begin n_err++; $display("FAIL reset_freq: got %0d want 0", freq); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        push_samples(16, 16'h0100, 16'h0100);
        n_cmp++; if (fft_start !== 1'b0) begin n_err++; $display("FAIL fill_start_early: got %b want 0", fft_start); end
        @(negedge clk);
        n_cmp++; if (fft_start !== 1'b1) begin n_err++; $display("FAIL fill_start_latency: got %b want 1", fft_start); end
        fft_rd_addr = 4'd3;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h0400) begin n_err++; $display("FAIL fill_rd_addr3: got %h want 0400", fft_rd_data); end
        fft_rd_addr = 4'd15;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h1000) begin n_err++; $display("FAIL fill_rd_addr15: got %h want 1000", fft_rd_data); end
        @(negedge clk);
        n_cmp++; if (fft_start !== 1'b0) begin n_err++; $display("FAIL fill_start_width: got %b want 0", fft_start); end
    endtask

    task automatic test_peak();
        send_bins(5, 32'h03000400, 2, 32'h04000200, 16);
        n_cmp++; if (freq_valid !== 1'b1) begin n_err++; $display("FAIL peak_freq_valid: got %b want 1", freq_valid); end
        n_cmp++; if (freq !== 4'd5) begin n_err++; $display("FAIL peak_freq: got %0d want 5", freq); end
        @(negedge clk);
        n_cmp++; if (freq_valid !== 1'b0) begin n_err++; $display("FAIL peak_fv_width: got %b want 0", freq_valid); end
        n_cmp++; if (freq !== 4'd5) begin n_err++; $display("FAIL peak_freq_hold: got %0d want 5", freq); end
    endtask

    task automatic test_tie();
        int cyc;
        push_samples(16, 16'h2000, 1);
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL tie_start_wait: got %0d want 1", cyc); end
        fft_rd_addr = 4'd0;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h2000) begin n_err++; $display("FAIL tie_rd_bank1: got %h want 2000", fft_rd_data); end
        n_cmp++; if (freq !== 4'd5) begin n_err++; $display("FAIL tie_freq_held: got %0d want 5", freq); end
        send_bins(2, 32'h01000000, 9, 32'h01000000, 16);
        n_cmp++; if (freq_valid !== 1'b1) begin n_err++; $display("FAIL tie_freq_valid: got %b want 1", freq_valid); end
        n_cmp++; if (freq !== 4'd2) begin n_err++; $display("FAIL tie_freq: got %0d want 2", freq); end
    endtask

    task automatic test_overflow();
        int s0;
        int cyc;
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i == 32) begin
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before_drop: got %b want 0", overflow); end
            end
            if (i == 33) begin
                n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_at_drop: got %b want 1", overflow); end
            end
            fir_valid = 1'b1;
            fir_d = 16'(i + 1);
        end
        @(negedge clk);
        fir_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (start_cnt - s0 != 1) begin n_err++; $display("FAIL ovf_start_count: got %0d want 1", start_cnt - s0); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        fft_rd_addr = 4'd15;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h0010) begin n_err++; $display("FAIL ovf_bank0_last: got %h want 0010", fft_rd_data); end
        send_bins(0, 32'h0, 0, 32'h0, 16);
        n_cmp++; if (freq_valid !== 1'b1) begin n_err++; $display("FAIL ovf_release_fv: got %b want 1", freq_valid); end
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL ovf_bank1_start: got %0d want 1", cyc); end
        fft_rd_addr = 4'd0;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h0011) begin n_err++; $display("FAIL ovf_bank1_first: got %h want 0011", fft_rd_data); end
        fft_rd_addr = 4'd15;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h0020) begin n_err++; $display("FAIL ovf_bank1_last: got %h want 0020", fft_rd_data); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        push_samples(16, 16'h4000, 1);
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL b2b_start0: got %0d want 1", cyc); end
        // Bank 1 finishes filling on the same edge bank 0 is released.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            fft_bin_valid = 1'b1;
            fft_bin = (i == 7) ? 32'h00100000 : 32'h0;
            fir_valid = 1'b1;
            fir_d = 16'(16'h5000 + i);
        end
        @(negedge clk);
        fft_bin_valid = 1'b0;
        fir_valid = 1'b0;
        n_cmp++; if (freq_valid !== 1'b1 || freq !== 4'd7) begin n_err++; $display("FAIL b2b_freq: got fv=%b freq=%0d want fv=1 freq=7", freq_valid, freq); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovf: got %b want 0", overflow); end
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL b2b_start1: got %0d want 1", cyc); end
        fft_rd_addr = 4'd15;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h500F) begin n_err++; $display("FAIL b2b_bank1_last: got %h want 500f", fft_rd_data); end
        push_samples(16, 16'h6000, 1);
        // Write bank is now bank 1, which is being released on the last beat.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            fft_bin_valid = 1'b1;
            fft_bin = 32'h0;
            fir_valid = (i == 15);
            fir_d = 16'h7777;
        end
        @(negedge clk);
        fft_bin_valid = 1'b0;
        fir_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL b2b_release_drop: got %b want 1", overflow); end
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL b2b_start2: got %0d want 1", cyc); end
        fft_rd_addr = 4'd0;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h6000) begin n_err++; $display("FAIL b2b_bank0_first: got %h want 6000", fft_rd_data); end
        push_samples(16, 16'h7000, 1);
        send_bins(0, 32'h0, 0, 32'h0, 16);
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL b2b_start3: got %0d want 1", cyc); end
        fft_rd_addr = 4'd0;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h7000) begin n_err++; $display("FAIL b2b_no_stray_write: got %h want 7000", fft_rd_data); end
        fft_rd_addr = 4'd15;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h700F) begin n_err++; $display("FAIL b2b_bank1_refill: got %h want 700f", fft_rd_data); end
    endtask

    task automatic test_done();
        int s0;
        int v0;
        int cyc;
        do_reset();
        s0 = start_cnt;
        v0 = fv_cnt;
        for (int f = 0; f < 10; f++) begin
            push_samples(16, f * 16, 1);
            wait_start(cyc);
            n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL done_start_f%0d: got %0d want 1", f, cyc); end
            send_bins(0, 32'h0, 0, 32'h0, 16);
            n_cmp++; if (freq_valid !== 1'b1 || freq !== 4'd0) begin n_err++; $display("FAIL done_fv_f%0d: got fv=%b freq=%0d want fv=1 freq=0", f, freq_valid, freq); end
            n_cmp++; if (done !== (f == 9)) begin n_err++; $display("FAIL done_level_f%0d: got %b want %b", f, done, (f == 9)); end
        end
        push_samples(16, 16'h0AAA, 1);
        repeat (20) @(negedge clk);
        n_cmp++; if (start_cnt - s0 != 10) begin n_err++; $display("FAIL done_start_total: got %0d want 10", start_cnt - s0); end
        n_cmp++; if (fv_cnt - v0 != 10) begin n_err++; $display("FAIL done_fv_total: got %0d want 10", fv_cnt - v0); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_held: got %b want 1", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL done_fir_ignored: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int s0;
        int v0;
        int cyc;
        do_reset();
        push_samples(16, 16'h0100, 1);
        wait_start(cyc);
        send_bins(5, 32'h03000400, 5, 32'h03000400, 16);
        push_samples(33, 16'h3000, 1);
        n_cmp++; if (overflow !== 1'b1 || freq !== 4'd5) begin n_err++; $display("FAIL mid_pre_state: got ovf=%b freq=%0d want ovf=1 freq=5", overflow, freq); end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            fft_bin_valid = 1'b1;
            fft_bin = 32'h0;
        end
        @(negedge clk);
        fft_bin_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (fft_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_start: got %b want 0", fft_start); end
        n_cmp++; if (freq_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_fv: got %b want 0", freq_valid); end
        n_cmp++; if (freq !== 4'd0) begin n_err++; $display("FAIL mid_rst_freq: got %0d want 0", freq); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %b want 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
        @(negedge clk);
        rst = 1'b1;
        s0 = start_cnt;
        v0 = fv_cnt;
        send_bins(0, 32'h7FFF0000, 0, 32'h7FFF0000, 9);
        repeat (2) @(negedge clk);
        n_cmp++; if (fv_cnt - v0 != 0 || start_cnt - s0 != 0) begin n_err++; $display("FAIL mid_stray_bins: got fv=%0d start=%0d want 0 0", fv_cnt - v0, start_cnt - s0); end
        push_samples(16, 16'h7100, 1);
        wait_start(cyc);
        n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL mid_restart: got %0d want 1", cyc); end
        fft_rd_addr = 4'd2;
        #1;
        n_cmp++; if (fft_rd_data !== 16'h7102) begin n_err++; $display("FAIL mid_restart_bank0: got %h want 7102", fft_rd_data); end
        send_bins(11, 32'hFC000000, 4, 32'h03000200, 16);
        n_cmp++; if (freq_valid !== 1'b1 || freq !== 4'd11) begin n_err++; $display("FAIL mid_neg_peak: got fv=%b freq=%0d want fv=1 freq=11", freq_valid, freq); end
    endtask

    initial begin
        rst = 1'b0;
        fir_valid = 1'b0;
        fir_d = '0;
        fft_rd_addr = '0;
        fft_bin_valid = 1'b0;
        fft_bin = '0;
        test_reset();
        test_fill();
        test_peak();
        test_tie();
        test_overflow();
        test_back_to_back();
        test_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
